// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states and
// the default operand width.
package seq_mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/mult_addsub.sv
// Combinational adder/subtractor used for each shift-add step of seq_mult.
// With sub=1 it computes x - y as x + ~y + 1.
module mult_addsub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + (y ^ {WIDTH{sub}}) + WIDTH'(sub);

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential multiplier, one shift-add step per clock, supporting
// unsigned and two's-complement operands.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand;
  logic             smode;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic             sub;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mplier_next;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (cnt == LAST);

  // The multiplier MSB carries negative weight in signed mode, so its step subtracts.
  assign addend = mplier[0] ? {smode & mcand[WIDTH-1], mcand} : '0;
  assign sub    = smode & last_step & mplier[0];

  mult_addsub #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .x  (acc),
    .y  (addend),
    .sub(sub),
    .sum(sum)
  );

  assign acc_next    = {smode & sum[WIDTH], sum[WIDTH:1]};
  assign mplier_next = {sum[0], mplier[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The low half of the product shifts in through mplier as its bits are consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      smode  <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
    end else if (accept) begin
      acc    <= '0;
      mplier <= b;
      mcand  <= a;
      smode  <= signed_mode;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mplier <= mplier_next;
      cnt    <= cnt + CW'(1);
      if (last_step) prod <= {acc_next[WIDTH-1:0], mplier_next};
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed latency/corner sequences at
// WIDTH=8, exhaustive WIDTH=4 and random WIDTH=16 against an arithmetic model.
module tb_seq_mult;

  logic clk;
  logic rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[8];

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8)
  );

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .prod(prod4)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .prod(prod16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference product: interpret operands as w-bit integers and truncate to 2w bits.
  function automatic logic [63:0] refProd(input logic [31:0] x, input logic [31:0] y,
                                          input bit s, input int w);
    longint xs, ys;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    xs = longint'(64'(x) & m);
    ys = longint'(64'(y) & m);
    if (s && x[w-1]) xs = xs - (longint'(1) << w);
    if (s && y[w-1]) ys = ys - (longint'(1) << w);
    return 64'(xs * ys) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit operation and check busy/done on every cycle of its latency.
  task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi, input bit si,
                               input logic [15:0] expP, input string tag);
    @(negedge clk);
    a8 = ai; b8 = bi; sm8 = si; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checkOutput({tag, " busy/done in CALC"}, {62'd0, busy8, done8}, 64'b10);
      @(negedge clk);
    end
    checkOutput({tag, " busy/done at DONE"}, {62'd0, busy8, done8}, 64'b01);
    checkOutput({tag, " prod"}, 64'(prod8), 64'(expP));
  endtask

  task automatic runOp4(input logic [3:0] ai, input logic [3:0] bi, input bit si);
    int n;
    @(negedge clk);
    a4 = ai; b4 = bi; sm4 = si; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w4 done seen", 64'(done4), 64'd1);
    if (done4) checkOutput($sformatf("w4 prod %0h*%0h s=%0d", ai, bi, si),
                           64'(prod4), refProd(32'(ai), 32'(bi), si, 4));
  endtask

  task automatic runOp16(input logic [15:0] ai, input logic [15:0] bi, input bit si);
    int n;
    @(negedge clk);
    a16 = ai; b16 = bi; sm16 = si; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 22) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w16 done seen", 64'(done16), 64'd1);
    if (done16) checkOutput($sformatf("w16 prod %0h*%0h s=%0d", ai, bi, si),
                            64'(prod16), refProd(32'(ai), 32'(bi), si, 16));
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int doneCount;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u ff*ff"};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80"};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080, "s 80*7f"};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF, "s ff*01"};
    vecs[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF, "u ff*01"};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, "s 7f*7f"};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s ff*ff"};
    vecs[7] = '{8'h00, 8'hAB, 1'b0, 16'h0000, "u 00*ab"};

    rst = 1'b1;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0;

    #1;
    checkOutput("reset busy/done w8", {62'd0, busy8, done8}, 64'd0);
    checkOutput("reset prod w8", 64'(prod8), 64'd0);
    checkOutput("reset prod w4", 64'(prod4), 64'd0);
    checkOutput("reset prod w16", 64'(prod16), 64'd0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].tag);

    // Back-to-back: new request held in the DONE cycle, first result must persist.
    applyStimulus(8'd7, 8'd9, 1'b0, 16'd63, "b2b first");
    a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checkOutput("b2b busy/done in CALC", {62'd0, busy8, done8}, 64'b10);
      checkOutput("b2b prod held", 64'(prod8), 64'd63);
      @(negedge clk);
    end
    checkOutput("b2b busy/done at DONE", {62'd0, busy8, done8}, 64'b01);
    checkOutput("b2b prod second", 64'(prod8), 64'd15);

    // Start pulses during CALC must not disturb the operation in flight.
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0; start8 = 1'b1;
    doneCount = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done8) begin
        doneCount++;
        checkOutput("ignored start prod", 64'(prod8), 64'd132);
      end
      start8 = (i == 2 || i == 5) ? 1'b1 : 1'b0;
      a8 = 8'd0; b8 = 8'd0;
    end
    checkOutput("ignored start done count", 64'(doneCount), 64'd1);

    // Reset in the 4th CALC cycle abandons the operation immediately.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; sm8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid reset busy/done", {62'd0, busy8, done8}, 64'd0);
    checkOutput("mid reset prod", 64'(prod8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) doneCount++;
    end
    checkOutput("mid reset no activity", 64'(doneCount), 64'd0);
    applyStimulus(8'd200, 8'd100, 1'b0, 16'd20000, "after reset");

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          runOp4(4'(x), 4'(y), s[0]);

    for (int i = 0; i < 2000; i++)
      runOp16(pick16(), pick16(), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
